// File: rtl/bsg_cache_pkg.sv
// Shared cache types: request opcodes, the decoded-operation record, and the
// pipe-entry declaration macro used by the registered decode stage.
package bsg_cache_pkg;

  localparam int bsg_cache_opcode_width_lp = 6;

  typedef enum logic [5:0] {
    LB        = 6'd0,
    LH        = 6'd1,
    LW        = 6'd2,
    LD        = 6'd3,
    LBU       = 6'd4,
    LHU       = 6'd5,
    LWU       = 6'd6,
    LDU       = 6'd7,
    SB        = 6'd8,
    SH        = 6'd9,
    SW        = 6'd10,
    SD        = 6'd11,
    LM        = 6'd12,
    SM        = 6'd13,
    TAGST     = 6'd16,
    TAGFL     = 6'd17,
    TAGLV     = 6'd18,
    TAGLA     = 6'd19,
    AFL       = 6'd24,
    AFLINV    = 6'd25,
    AINV      = 6'd26,
    ALOCK     = 6'd27,
    AUNLOCK   = 6'd28,
    AMOSWAP_W = 6'd32,
    AMOADD_W  = 6'd33,
    AMOXOR_W  = 6'd34,
    AMOAND_W  = 6'd35,
    AMOOR_W   = 6'd36,
    AMOMIN_W  = 6'd37,
    AMOMAX_W  = 6'd38,
    AMOMINU_W = 6'd39,
    AMOMAXU_W = 6'd40,
    AMOSWAP_D = 6'd48,
    AMOADD_D  = 6'd49,
    AMOXOR_D  = 6'd50,
    AMOAND_D  = 6'd51,
    AMOOR_D   = 6'd52,
    AMOMIN_D  = 6'd53,
    AMOMAX_D  = 6'd54,
    AMOMINU_D = 6'd55,
    AMOMAXU_D = 6'd56
  } bsg_cache_opcode_e;

  typedef struct packed {
    logic [1:0] data_size_op;
    logic sigext_op;
    logic mask_op;
    logic ld_op;
    logic st_op;
    logic tagst_op;
    logic tagfl_op;
    logic taglv_op;
    logic tagla_op;
    logic afl_op;
    logic aflinv_op;
    logic ainv_op;
    logic alock_op;
    logic aunlock_op;
    logic tag_read_op;
    logic atomic_op;
    logic amoswap_op;
    logic amoadd_op;
    logic amoxor_op;
    logic amoand_op;
    logic amoor_op;
    logic amomin_op;
    logic amomax_op;
    logic amominu_op;
    logic amomaxu_op;
  } bsg_cache_decode_s;

endpackage

// One buffered decode result; widths follow the instantiating stage.
`ifndef BSG_CACHE_DECODE_PIPE_ENTRY_S_DEFINED
`define BSG_CACHE_DECODE_PIPE_ENTRY_S_DEFINED
`define BSG_CACHE_DECLARE_DECODE_PIPE_ENTRY_S(addr_width_mp, data_width_mp) \
  typedef struct packed { \
    bsg_cache_pkg::bsg_cache_decode_s decode; \
    logic [(addr_width_mp)-1:0] addr; \
    logic [(data_width_mp)-1:0] data; \
    logic [((data_width_mp)/8)-1:0] mask; \
    logic illegal; \
    logic misaligned; \
  } bsg_cache_decode_pipe_entry_s
`endif

// File: rtl/bsg_cache_decode_skid.sv
// Generic two-entry buffer: ready/valid on the input, valid/yumi on the output.
// The head entry is always held in its own register so outputs are registered.
module bsg_cache_decode_skid
  #(parameter int width_p = 1)
  (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
  );

  logic [1:0]         count;
  logic [width_p-1:0] head;
  logic [width_p-1:0] tail;
  logic               enq;
  logic               deq;

  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign data_o  = head;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Occupancy plus head/tail storage; a new entry goes straight to head when head is free or leaving
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + {1'b0, enq} - {1'b0, deq};
      if (enq && ((count == 2'd0) || ((count == 2'd1) && deq))) begin
        head <= data_i;
      end else if ((count == 2'd2) && deq) begin
        head <= tail;
      end
      if (enq && (count == 2'd1) && !deq) begin
        tail <= data_i;
      end
    end
  end

  // Consuming from an empty buffer is a protocol error on the downstream side
  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("bsg_cache_decode_skid: yumi_i asserted while empty");

endmodule

// File: rtl/bsg_cache_decode_pipe.sv
// Registered cache-request decode stage: decodes opcode, builds the byte-lane
// mask and illegal/misaligned flags, and buffers results in a 2-entry skid.
module bsg_cache_decode_pipe
  import bsg_cache_pkg::*;
  #(parameter int addr_width_p = 32,
    parameter int data_width_p = 64,
    localparam int data_mask_width_lp = data_width_p / 8,
    localparam int lg_data_mask_width_lp = $clog2(data_mask_width_lp))
  (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  bsg_cache_opcode_e             opcode_i,
    input  logic [addr_width_p-1:0]       addr_i,
    input  logic [data_width_p-1:0]       data_i,
    input  logic [data_mask_width_lp-1:0] mask_i,
    output logic                          v_o,
    input  logic                          yumi_i,
    output bsg_cache_decode_s             decode_o,
    output logic [addr_width_p-1:0]       addr_o,
    output logic [data_width_p-1:0]       data_o,
    output logic [data_mask_width_lp-1:0] mask_o,
    output logic                          illegal_o,
    output logic                          misaligned_o
  );

  if (!((data_width_p == 32) || (data_width_p == 64))) begin : g_bad_width
    $error("bsg_cache_decode_pipe: data_width_p must be 32 or 64");
  end

  `BSG_CACHE_DECLARE_DECODE_PIPE_ENTRY_S(addr_width_p, data_width_p);

  bsg_cache_decode_s                  dec;
  logic                               legal;
  logic                               illegal;
  logic                               misaligned;
  logic                               access;
  logic [15:0]                        align;
  logic [data_mask_width_lp-1:0]      mask;
  logic [lg_data_mask_width_lp-1:0]   offset;
  bsg_cache_decode_pipe_entry_s       entry_in;
  bsg_cache_decode_pipe_entry_s       entry_out;

  assign offset = addr_i[lg_data_mask_width_lp-1:0];

  // Classify the opcode into access size, direction and maintenance flags; unknown or too-wide ops become illegal
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode_i)
      LB:      begin dec.ld_op = 1'b1; dec.sigext_op = 1'b1; dec.data_size_op = 2'd0; end
      LH:      begin dec.ld_op = 1'b1; dec.sigext_op = 1'b1; dec.data_size_op = 2'd1; end
      LW:      begin dec.ld_op = 1'b1; dec.sigext_op = 1'b1; dec.data_size_op = 2'd2; end
      LD:      begin dec.ld_op = 1'b1; dec.sigext_op = 1'b1; dec.data_size_op = 2'd3; end
      LBU:     begin dec.ld_op = 1'b1; dec.data_size_op = 2'd0; end
      LHU:     begin dec.ld_op = 1'b1; dec.data_size_op = 2'd1; end
      LWU:     begin dec.ld_op = 1'b1; dec.data_size_op = 2'd2; end
      LDU:     begin dec.ld_op = 1'b1; dec.data_size_op = 2'd3; end
      SB:      begin dec.st_op = 1'b1; dec.data_size_op = 2'd0; end
      SH:      begin dec.st_op = 1'b1; dec.data_size_op = 2'd1; end
      SW:      begin dec.st_op = 1'b1; dec.data_size_op = 2'd2; end
      SD:      begin dec.st_op = 1'b1; dec.data_size_op = 2'd3; end
      LM:      begin dec.ld_op = 1'b1; dec.mask_op = 1'b1; dec.data_size_op = 2'(lg_data_mask_width_lp); end
      SM:      begin dec.st_op = 1'b1; dec.mask_op = 1'b1; dec.data_size_op = 2'(lg_data_mask_width_lp); end
      TAGST:   dec.tagst_op   = 1'b1;
      TAGFL:   dec.tagfl_op   = 1'b1;
      TAGLV:   dec.taglv_op   = 1'b1;
      TAGLA:   dec.tagla_op   = 1'b1;
      AFL:     dec.afl_op     = 1'b1;
      AFLINV:  dec.aflinv_op  = 1'b1;
      AINV:    dec.ainv_op    = 1'b1;
      ALOCK:   dec.alock_op   = 1'b1;
      AUNLOCK: dec.aunlock_op = 1'b1;
      AMOSWAP_W, AMOADD_W, AMOXOR_W, AMOAND_W, AMOOR_W,
      AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W:
               begin dec.atomic_op = 1'b1; dec.data_size_op = 2'd2; end
      AMOSWAP_D, AMOADD_D, AMOXOR_D, AMOAND_D, AMOOR_D,
      AMOMIN_D, AMOMAX_D, AMOMINU_D, AMOMAXU_D:
               begin dec.atomic_op = 1'b1; dec.data_size_op = 2'd3; end
      default: legal = 1'b0;
    endcase
    case (opcode_i)
      AMOSWAP_W, AMOSWAP_D: dec.amoswap_op = 1'b1;
      AMOADD_W,  AMOADD_D:  dec.amoadd_op  = 1'b1;
      AMOXOR_W,  AMOXOR_D:  dec.amoxor_op  = 1'b1;
      AMOAND_W,  AMOAND_D:  dec.amoand_op  = 1'b1;
      AMOOR_W,   AMOOR_D:   dec.amoor_op   = 1'b1;
      AMOMIN_W,  AMOMIN_D:  dec.amomin_op  = 1'b1;
      AMOMAX_W,  AMOMAX_D:  dec.amomax_op  = 1'b1;
      AMOMINU_W, AMOMINU_D: dec.amominu_op = 1'b1;
      AMOMAXU_W, AMOMAXU_D: dec.amomaxu_op = 1'b1;
      default: ;
    endcase
    dec.sigext_op   = dec.sigext_op | dec.atomic_op;
    dec.tag_read_op = ~dec.tagst_op;
    illegal = ~legal | ((dec.data_size_op == 2'd3) && (data_width_p == 32));
    if (illegal) begin
      dec = '0;
      dec.tag_read_op = 1'b1;
    end
  end

  // Byte-lane mask from size and low address bits; misaligned accesses get an empty mask
  always_comb begin
    access     = dec.ld_op | dec.st_op | dec.atomic_op;
    align      = (16'd1 << dec.data_size_op) - 16'd1;
    misaligned = access & ((align & 16'(offset)) != 16'd0);
    mask       = '0;
    if (dec.mask_op) begin
      mask = mask_i;
    end else if (access) begin
      mask = data_mask_width_lp'(((16'd1 << (16'd1 << dec.data_size_op)) - 16'd1) << offset);
    end
    if (misaligned) begin
      mask = '0;
    end
  end

  assign entry_in = '{decode: dec, addr: addr_i, data: data_i, mask: mask,
                      illegal: illegal, misaligned: misaligned};

  bsg_cache_decode_skid #(.width_p($bits(bsg_cache_decode_pipe_entry_s))) skid (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_i    (entry_in),
    .v_o       (v_o),
    .data_o    (entry_out),
    .yumi_i    (yumi_i)
  );

  assign decode_o     = entry_out.decode;
  assign addr_o       = entry_out.addr;
  assign data_o       = entry_out.data;
  assign mask_o       = entry_out.mask;
  assign illegal_o    = entry_out.illegal;
  assign misaligned_o = entry_out.misaligned;

endmodule
